video_cleaner: RTL and testbench



---
 rtl/video_cleaner.sv | 141 ++++++++++++++
 tb/tb_video_cleaner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_cleaner.sv
// video_cleaner: detects sync polarity, normalises sync to active high, masks RGB in blanking and
// derives DE. Defining VIDEO_CLEANER_VALIGN_EN aligns VBlank/VSync changes to line starts.
module video_cleaner #(
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned HCNT_BITS  = 12,
  parameter int unsigned VCNT_BITS  = 20
) (
  input  logic                  clk_vid,
  input  logic                  reset_n,
  input  logic                  ce_pix,
  input  logic [COLOR_BITS-1:0] R,
  input  logic [COLOR_BITS-1:0] G,
  input  logic [COLOR_BITS-1:0] B,
  input  logic                  HSync,
  input  logic                  VSync,
  input  logic                  HBlank,
  input  logic                  VBlank,
  output logic [COLOR_BITS-1:0] VGA_R,
  output logic [COLOR_BITS-1:0] VGA_G,
  output logic [COLOR_BITS-1:0] VGA_B,
  output logic                  HSync_out,
  output logic                  VSync_out,
  output logic                  HBlank_out,
  output logic                  VBlank_out,
  output logic                  DE_out,
  output logic                  hs_pol,
  output logic                  vs_pol
);

  logic [COLOR_BITS-1:0] r_q, g_q, b_q;
  logic                  hs_q, vs_q, hb_q, vb_q;
  logic                  hs_prev_q, vs_prev_q;

  logic [HCNT_BITS-1:0]  h_cnt_q, h_cnt_d, h_hi_q, h_hi_d, h_lo_q, h_lo_d;
  logic [VCNT_BITS-1:0]  v_cnt_q, v_cnt_d, v_hi_q, v_hi_d, v_lo_q, v_lo_d;
  logic                  hs_pol_d, vs_pol_d;

  logic                  hs_n, vs_n, vsync_d, vblank_d, blank;

  // Horizontal level-duration measurement; the longer level is the inactive one.
  always_comb begin
    h_cnt_d  = h_cnt_q;
    h_hi_d   = h_hi_q;
    h_lo_d   = h_lo_q;
    hs_pol_d = hs_pol;
    if (hs_q != hs_prev_q) begin
      h_cnt_d = HCNT_BITS'(1);
      if (hs_prev_q) h_hi_d = h_cnt_q;
      else           h_lo_d = h_cnt_q;
      if (h_hi_d != h_lo_d) hs_pol_d = (h_hi_d > h_lo_d);
    end else if (h_cnt_q != '1) begin
      h_cnt_d = h_cnt_q + HCNT_BITS'(1);
    end
  end

  always_comb begin
    v_cnt_d  = v_cnt_q;
    v_hi_d   = v_hi_q;
    v_lo_d   = v_lo_q;
    vs_pol_d = vs_pol;
    if (vs_q != vs_prev_q) begin
      v_cnt_d = VCNT_BITS'(1);
      if (vs_prev_q) v_hi_d = v_cnt_q;
      else           v_lo_d = v_cnt_q;
      if (v_hi_d != v_lo_d) vs_pol_d = (v_hi_d > v_lo_d);
    end else if (v_cnt_q != '1) begin
      v_cnt_d = v_cnt_q + VCNT_BITS'(1);
    end
  end

  assign hs_n = hs_q ^ hs_pol;
  assign vs_n = vs_q ^ vs_pol;

`ifdef VIDEO_CLEANER_VALIGN_EN
  // HBlank_out / HSync_out hold the previous stage-0 values, so they serve as edge history.
  assign vblank_d = (hb_q && !HBlank_out) ? vb_q : VBlank_out;
  assign vsync_d  = (hs_n && !HSync_out)  ? vs_n : VSync_out;
`else
  assign vblank_d = vb_q;
  assign vsync_d  = vs_n;
`endif

  assign blank = hb_q | vblank_d;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      h_cnt_q    <= '0;
      h_hi_q     <= '0;
      h_lo_q     <= '0;
      v_cnt_q    <= '0;
      v_hi_q     <= '0;
      v_lo_q     <= '0;
      hs_pol     <= 1'b0;
      vs_pol     <= 1'b0;
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      HSync_out  <= 1'b0;
      VSync_out  <= 1'b0;
      HBlank_out <= 1'b0;
      VBlank_out <= 1'b0;
      DE_out     <= 1'b0;
    end else if (ce_pix) begin
      r_q        <= R;
      g_q        <= G;
      b_q        <= B;
      hs_q       <= HSync;
      vs_q       <= VSync;
      hb_q       <= HBlank;
      vb_q       <= VBlank;
      hs_prev_q  <= hs_q;
      vs_prev_q  <= vs_q;
      h_cnt_q    <= h_cnt_d;
      h_hi_q     <= h_hi_d;
      h_lo_q     <= h_lo_d;
      v_cnt_q    <= v_cnt_d;
      v_hi_q     <= v_hi_d;
      v_lo_q     <= v_lo_d;
      hs_pol     <= hs_pol_d;
      vs_pol     <= vs_pol_d;
      VGA_R      <= blank ? '0 : r_q;
      VGA_G      <= blank ? '0 : g_q;
      VGA_B      <= blank ? '0 : b_q;
      HSync_out  <= hs_n;
      VSync_out  <= vsync_d;
      HBlank_out <= hb_q;
      VBlank_out <= vblank_d;
      DE_out     <= ~blank;
    end
  end

endmodule

// File: tb/tb_video_cleaner.sv
// Self-checking bench for video_cleaner: run-length polarity model over the sampled input history,
// compared against the DUT every clock, plus literal checks on pulse widths and polarity.
module tb_video_cleaner;

  localparam int unsigned CB   = 8;
  localparam int unsigned HMAX = 4095;
  localparam int unsigned VMAX = (1 << 20) - 1;

  logic          clk_vid = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_pix  = 1'b0;
  logic [CB-1:0] R = '0, G = '0, B = '0;
  logic          HSync = 1'b0, VSync = 1'b0, HBlank = 1'b0, VBlank = 1'b0;
  logic [CB-1:0] VGA_R, VGA_G, VGA_B;
  logic          HSync_out, VSync_out, HBlank_out, VBlank_out, DE_out, hs_pol, vs_pol;

  video_cleaner dut (
    .clk_vid    (clk_vid),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .R          (R),
    .G          (G),
    .B          (B),
    .HSync      (HSync),
    .VSync      (VSync),
    .HBlank     (HBlank),
    .VBlank     (VBlank),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .HSync_out  (HSync_out),
    .VSync_out  (VSync_out),
    .HBlank_out (HBlank_out),
    .VBlank_out (VBlank_out),
    .DE_out     (DE_out),
    .hs_pol     (hs_pol),
    .vs_pol     (vs_pol)
  );

  always #5 clk_vid = ~clk_vid;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: sync sample histories (oldest first), last stored lengths, and expected outputs.
  bit            hh[$];
  bit            vh[$];
  int unsigned   mhi, mlo, mvhi, mvlo;
  bit            mhpol, mvpol;
  logic [CB-1:0] s_r, s_g, s_b;
  bit            s_hs, s_vs, s_hb, s_vb, phb2;
  logic [CB-1:0] er, eg, eb;
  bit            ehs, evs, ehb, evb, ede;

  // Output pulse-width trackers, counted in ce_pix cycles.
  int cur_hs, last_hs, cur_vs, last_vs, cur_de, last_de_lo;

  // Length of the run that ended just before the newest sample, capped at the counter max.
  function automatic int unsigned run_back(input bit v, input int unsigned cap);
    int unsigned len;
    int          i;
    bit          lvl;
    len = 0;
    i   = v ? vh.size() - 2 : hh.size() - 2;
    lvl = v ? vh[i] : hh[i];
    while (i >= 0 && ((v ? vh[i] : hh[i]) == lvl)) begin
      if (len < cap) len++;
      i--;
    end
    return len;
  endfunction

  task automatic m_reset();
    hh.delete(); vh.delete();
    hh.push_back(1'b0); vh.push_back(1'b0);
    mhi = 0; mlo = 0; mvhi = 0; mvlo = 0; mhpol = 0; mvpol = 0;
    s_r = '0; s_g = '0; s_b = '0; s_hs = 0; s_vs = 0; s_hb = 0; s_vb = 0; phb2 = 0;
    er = '0; eg = '0; eb = '0; ehs = 0; evs = 0; ehb = 0; evb = 0; ede = 0;
    cur_hs = 0; cur_vs = 0; cur_de = 0;
  endtask

  task automatic m_step();
    bit          hsn, vsn;
    int unsigned len;
    hsn = s_hs ^ mhpol;
    vsn = s_vs ^ mvpol;
`ifdef VIDEO_CLEANER_VALIGN_EN
    if (s_hb && !phb2) evb = s_vb;
    if (hsn && !ehs)   evs = vsn;
`else
    evb = s_vb;
    evs = vsn;
`endif
    ehs = hsn;
    ehb = s_hb;
    ede = !(s_hb || evb);
    er  = ede ? s_r : '0;
    eg  = ede ? s_g : '0;
    eb  = ede ? s_b : '0;
    // A level change between the two newest samples is judged now and used from the next pixel.
    if (hh.size() >= 2 && hh[hh.size()-1] != hh[hh.size()-2]) begin
      len = run_back(1'b0, HMAX);
      if (hh[hh.size()-2]) mhi = len; else mlo = len;
      if (mhi != mlo) mhpol = (mhi > mlo);
    end
    if (vh.size() >= 2 && vh[vh.size()-1] != vh[vh.size()-2]) begin
      len = run_back(1'b1, VMAX);
      if (vh[vh.size()-2]) mvhi = len; else mvlo = len;
      if (mvhi != mvlo) mvpol = (mvhi > mvlo);
    end
    phb2 = s_hb;
    s_r = R; s_g = G; s_b = B; s_hs = HSync; s_vs = VSync; s_hb = HBlank; s_vb = VBlank;
    hh.push_back(HSync);
    vh.push_back(VSync);
    if (hh.size() > 6000) void'(hh.pop_front());
  endtask

  task automatic track(input bit lvl, inout int cur, inout int last);
    if (lvl) cur++;
    else if (cur > 0) begin
      last = cur;
      cur  = 0;
    end
  endtask

  // Single compare process: advance the model on each sampled edge, then check every output.
  always @(posedge clk_vid) begin
    #1;
    if (!reset_n) m_reset();
    else if (ce_pix) begin
      m_step();
      track(HSync_out, cur_hs, last_hs);
      track(VSync_out, cur_vs, last_vs);
      track(!DE_out, cur_de, last_de_lo);
    end
    chk("VGA_R", VGA_R, er);
    chk("VGA_G", VGA_G, eg);
    chk("VGA_B", VGA_B, eb);
    chk("HSync_out", HSync_out, ehs);
    chk("VSync_out", VSync_out, evs);
    chk("HBlank_out", HBlank_out, ehb);
    chk("VBlank_out", VBlank_out, evb);
    chk("DE_out", DE_out, ede);
    chk("hs_pol", hs_pol, mhpol);
    chk("vs_pol", vs_pol, mvpol);
  end

  bit gaps = 0;

  task automatic pix(input logic [CB-1:0] r, g, b, input bit hs, vs, hb, vb);
    while (gaps && $urandom_range(3) == 0) begin
      @(negedge clk_vid);
      ce_pix = 1'b0;
      R = CB'($urandom); G = CB'($urandom); B = CB'($urandom);
      HSync = 1'($urandom); VSync = 1'($urandom); HBlank = 1'($urandom); VBlank = 1'($urandom);
    end
    @(negedge clk_vid);
    ce_pix = 1'b1;
    R = r; G = g; B = b; HSync = hs; VSync = vs; HBlank = hb; VBlank = vb;
  endtask

  task automatic run_line(input int len, input int hs_w, input bit hinv, input int hb_w,
                          input bit vs_act, input bit vinv, input int vb_from, input bit fixed);
    for (int i = 0; i < len; i++) begin
      logic [CB-1:0] r, g, b;
      if (fixed) begin
        r = 8'hFF; g = 8'h80; b = 8'h01;
      end else begin
        r = CB'($urandom); g = CB'($urandom); b = CB'($urandom);
      end
      pix(r, g, b, (i < hs_w) ^ hinv, vs_act ^ vinv, i >= len - hb_w, i >= vb_from);
    end
  endtask

  task automatic settle();
    @(negedge clk_vid);
    ce_pix = 1'b0;
    @(negedge clk_vid);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_vid);
    reset_n = 1'b1;

    // Active-low HSync, 800-pixel lines with 160-pixel HBlank and fixed colour.
    for (int l = 0; l < 4; l++) run_line(800, 96, 1'b1, 160, 1'b0, 1'b0, 800, 1'b1);
    settle();
    chk("hs_pol_active_low", hs_pol, 1'b1);
    chk("hs_out_width", last_hs, 96);
    chk("de_low_width", last_de_lo, 160);

    // Active-high VSync: 2-line pulse in 40-line frames of 32 pixels, with ce_pix gaps.
    gaps = 1;
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 40; l++)
        run_line(32, 4, 1'b1, 8, l < 2, 1'b0, (l < 5) ? 0 : 32, 1'b0);
    settle();
    chk("vs_pol_active_high", vs_pol, 1'b0);
    chk("vs_out_width", last_vs, 64);
    chk("hs_pol_kept", hs_pol, 1'b1);

    // Saturation: both levels longer than the counter range compare equal.
    gaps = 0;
    for (int i = 0; i < 5000; i++) pix(8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5000; i++) pix(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)    pix(8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("hs_pol_saturated", hs_pol, 1'b1);

    // Reset mid-stream with ce_pix toggling.
    gaps = 1;
    run_line(24, 3, 1'b0, 4, 1'b1, 1'b0, 10, 1'b0);
    @(negedge clk_vid);
    reset_n = 1'b0;
    #1;
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    chk("rst_ctl", {HSync_out, VSync_out, HBlank_out, VBlank_out, DE_out, hs_pol, vs_pol}, 0);
    repeat (6) begin
      @(negedge clk_vid);
      ce_pix = 1'($urandom);
    end
    reset_n = 1'b1;

    // Randomised frames: random geometry, polarities and mid-line VBlank edges.
    for (int f = 0; f < 12; f++) begin
      int len, nl, hsw, hbw, vsl, vbl, vbpos;
      bit hinv, vinv;
      len   = $urandom_range(48, 16);
      nl    = $urandom_range(30, 10);
      hsw   = $urandom_range(len / 3, 1);
      hbw   = $urandom_range(len / 2, 2);
      vsl   = $urandom_range(3, 1);
      vbl   = $urandom_range(5, vsl);
      vbpos = $urandom_range(len - 1, 1);
      hinv  = 1'($urandom);
      vinv  = 1'($urandom);
      for (int l = 0; l < nl; l++)
        run_line(len, hsw, hinv, hbw, l < vsl, vinv,
                 (l < vbl) ? 0 : ((l == nl - 1) ? vbpos : len), 1'b0);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
